mem_stage: RTL and testbench

Memory stage of the five-stage in-order pipeline. Sits between the AGEX latch and the WB stage. Loads and stores go to a variable-latency data memory through a req/ack handshake. The upstream pipeline stalls while an access is outstanding. Results, load data and exception flags are registered into the MEM latch for writeback.

---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores over a req/ack data-memory handshake and
// registers results, load data and exception flags into the MEM latch.
module mem_stage #(
  parameter int DBITS   = 32,
  parameter int REGBITS = 5,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DBITS-1:0]   in_pc,
  input  logic [3:0]         in_memop,
  input  logic [DBITS-1:0]   in_result,
  input  logic [DBITS-1:0]   in_sdata,
  input  logic               in_wr_reg,
  input  logic [REGBITS-1:0] in_rd,
  output logic               stall_out,
  output logic               hz_valid,
  output logic               hz_is_load,
  output logic [REGBITS-1:0] hz_rd,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DBITS-3:0]   dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [DBITS-1:0]   dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DBITS-1:0]   dmem_rdata,
  output logic               out_valid,
  output logic [DBITS-1:0]   out_pc,
  output logic               out_wr_reg,
  output logic [REGBITS-1:0] out_rd,
  output logic [DBITS-1:0]   out_wdata,
  output logic               out_misaligned,
  output logic               bus_fault,
  output logic [31:0]        stall_cycles
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

  state_t             state_reg;
  logic [CW-1:0]      wait_cnt_reg;
  logic [31:0]        stall_cycles_reg;
  logic               out_valid_reg, out_wr_reg_reg, out_misaligned_reg;
  logic [DBITS-1:0]   out_pc_reg, out_wdata_reg;
  logic [REGBITS-1:0] out_rd_reg;

  logic [1:0]       off;
  logic             is_load, is_store, is_mem, is_byte, is_half, is_word;
  logic             aligned, issuable, capture;
  logic [DBITS-1:0] shifted, load_data;

  assign off      = in_result[1:0];
  assign is_load  = (in_memop >= 4'd1) && (in_memop <= 4'd5);
  assign is_store = (in_memop >= 4'd6) && (in_memop <= 4'd8);
  assign is_mem   = is_load || is_store;
  assign is_byte  = (in_memop == 4'd1) || (in_memop == 4'd4) || (in_memop == 4'd6);
  assign is_half  = (in_memop == 4'd2) || (in_memop == 4'd5) || (in_memop == 4'd7);
  assign is_word  = (in_memop == 4'd3) || (in_memop == 4'd8);
  assign aligned  = is_half ? !off[0] : (is_word ? (off == 2'b00) : 1'b1);
  assign issuable = in_valid && is_mem && aligned;

  // WAIT keeps requesting without re-qualifying: upstream holds in_* stable.
  assign dmem_req  = !reset && ((state_reg == IDLE && issuable) || state_reg == WAIT);
  assign stall_out = !reset && ((state_reg == FAULT) || (dmem_req && !dmem_ack));
  assign capture   = (state_reg != FAULT) && !stall_out;

  assign hz_valid   = in_valid && in_wr_reg;
  assign hz_is_load = is_load;
  assign hz_rd      = in_rd;

  assign dmem_we   = is_store;
  assign dmem_addr = in_result[DBITS-1:2];

  always_comb begin
    dmem_be = 4'b1111;
    if (is_store && is_byte)
      dmem_be = 4'b0001 << off;
    else if (is_store && is_half)
      dmem_be = 4'b0011 << off;
  end

  // Replicate the store byte/halfword across all lanes; byte enables pick the live one.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign dmem_wdata[8*gi +: 8] = is_byte ? in_sdata[7:0] :
                                     is_half ? in_sdata[8*(gi%2) +: 8] :
                                               in_sdata[8*gi +: 8];
    end
  endgenerate

  // Aligned accesses make a byte-offset shift also select the right halfword.
  assign shifted = dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    case (in_memop)
      4'd1:    load_data = {{(DBITS-8){shifted[7]}}, shifted[7:0]};
      4'd2:    load_data = {{(DBITS-16){shifted[15]}}, shifted[15:0]};
      4'd4:    load_data = {{(DBITS-8){1'b0}}, shifted[7:0]};
      4'd5:    load_data = {{(DBITS-16){1'b0}}, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      wait_cnt_reg       <= '0;
      stall_cycles_reg   <= '0;
      out_valid_reg      <= 1'b0;
      out_pc_reg         <= '0;
      out_wr_reg_reg     <= 1'b0;
      out_rd_reg         <= '0;
      out_wdata_reg      <= '0;
      out_misaligned_reg <= 1'b0;
    end else begin
      if (stall_out && stall_cycles_reg != 32'hFFFF_FFFF)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;

      case (state_reg)
        IDLE: begin
          if (issuable && !dmem_ack) begin
            state_reg    <= WAIT;
            wait_cnt_reg <= CW'(1);
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_reg <= IDLE;
          end else if (wait_cnt_reg == CW'(TIMEOUT)) begin
            state_reg     <= FAULT;
            out_valid_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase

      if (capture) begin
        out_valid_reg      <= in_valid;
        out_pc_reg         <= in_pc;
        out_rd_reg         <= in_rd;
        out_wr_reg_reg     <= in_valid && in_wr_reg && !is_store && !(is_mem && !aligned);
        out_misaligned_reg <= in_valid && is_mem && !aligned;
        out_wdata_reg      <= (in_valid && is_load && aligned) ? load_data : in_result;
      end
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_pc         = out_pc_reg;
  assign out_wr_reg     = out_wr_reg_reg;
  assign out_rd         = out_rd_reg;
  assign out_wdata      = out_wdata_reg;
  assign out_misaligned = out_misaligned_reg;
  assign bus_fault      = (state_reg == FAULT);
  assign stall_cycles   = stall_cycles_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an arithmetic
// reference model of load extraction, store lanes, stalls and faults.
module tb_mem_stage;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [3:0]  in_memop;
  logic [31:0] in_result;
  logic [31:0] in_sdata;
  logic        in_wr_reg;
  logic [4:0]  in_rd;
  logic        stall_out, hz_valid, hz_is_load;
  logic [4:0]  hz_rd;
  logic        dmem_req, dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid, out_wr_reg, out_misaligned, bus_fault;
  logic [31:0] out_pc, out_wdata, stall_cycles;
  logic [4:0]  out_rd;

  int n_vec = 0;
  int n_err = 0;
  int model_stalls = 0;

  mem_stage #(.DBITS(32), .REGBITS(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_memop(in_memop),
    .in_result(in_result), .in_sdata(in_sdata), .in_wr_reg(in_wr_reg), .in_rd(in_rd),
    .stall_out(stall_out), .hz_valid(hz_valid), .hz_is_load(hz_is_load), .hz_rd(hz_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_wr_reg(out_wr_reg), .out_rd(out_rd),
    .out_wdata(out_wdata), .out_misaligned(out_misaligned),
    .bus_fault(bus_fault), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 0; in_pc = 0; in_memop = 0; in_result = 0; in_sdata = 0;
    in_wr_reg = 0; in_rd = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic reset_dut();
    reset = 1;
    drive_idle();
    @(posedge clk); #1;
    reset = 0;
    model_stalls = 0;
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_pc"}, out_pc, 0);
    check({tag, "_wr"}, out_wr_reg, 0);
    check({tag, "_rd"}, out_rd, 0);
    check({tag, "_wdata"}, out_wdata, 0);
    check({tag, "_mis"}, out_misaligned, 0);
    check({tag, "_fault"}, bus_fault, 0);
    check({tag, "_stallcnt"}, stall_cycles, 0);
  endtask

  // One instruction through the stage; ack arrives on request cycle index 'delay'.
  task automatic do_op(input logic v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input logic wr, input logic [4:0] rd, input int delay);
    int sz, sh, cyc;
    bit is_ld, is_st, mem, al, req, done;
    logic [31:0] pc, v32, exp_be, exp_wd, exp_w;
    pc = $urandom;
    in_valid = v; in_pc = pc; in_memop = op; in_result = addr; in_sdata = sdata;
    in_wr_reg = wr; in_rd = rd; dmem_rdata = rdata;

    is_ld = (op >= 1 && op <= 5);
    is_st = (op >= 6 && op <= 8);
    mem   = is_ld || is_st;
    sz    = (op == 1 || op == 4 || op == 6) ? 1 : (op == 2 || op == 5 || op == 7) ? 2 : 4;
    al    = (addr % sz) == 0;
    req   = v && mem && al;

    exp_be = 32'hF;
    exp_wd = sdata;
    if (op == 6) begin exp_be = 32'd1 << (addr % 4); exp_wd = (sdata & 32'hFF) * 32'h0101_0101; end
    if (op == 7) begin exp_be = 32'd3 << (addr % 4); exp_wd = (sdata & 32'hFFFF) * 32'h0001_0001; end

    exp_w = addr;
    if (v && is_ld && al) begin
      if (sz == 1) begin
        sh = 8 * (addr % 4);
        v32 = (rdata >> sh) & 32'hFF;
        exp_w = (op == 1 && v32 >= 32'h80) ? (v32 | 32'hFFFF_FF00) : v32;
      end else if (sz == 2) begin
        sh = 16 * ((addr % 4) / 2);
        v32 = (rdata >> sh) & 32'hFFFF;
        exp_w = (op == 2 && v32 >= 32'h8000) ? (v32 | 32'hFFFF_0000) : v32;
      end else begin
        exp_w = rdata;
      end
    end

    cyc = 0;
    done = 0;
    while (!done) begin
      dmem_ack = req && (cyc == delay);
      @(negedge clk);
      check("req", dmem_req, req);
      check("stall", stall_out, req && (cyc < delay));
      if (cyc == 0) begin
        check("hz_valid", hz_valid, v && wr);
        check("hz_is_load", hz_is_load, is_ld);
        check("hz_rd", hz_rd, rd);
        if (req) begin
          check("addr", dmem_addr, addr >> 2);
          check("we", dmem_we, is_st);
          check("be", dmem_be, exp_be);
          if (is_st) check("wdata_st", dmem_wdata, exp_wd);
        end
      end else begin
        check("addr_hold", dmem_addr, addr >> 2);
      end
      @(posedge clk); #1;
      if (!req || cyc >= delay) done = 1;
      cyc++;
    end
    dmem_ack = 0;
    if (req) model_stalls += delay;

    check("out_valid", out_valid, v);
    check("out_mis", out_misaligned, v && mem && !al);
    check("out_wr", out_wr_reg, v && wr && !is_st && !(mem && !al));
    if (v) begin
      check("out_pc", out_pc, pc);
      check("out_rd", out_rd, rd);
      if (!is_st) check("out_wdata", out_wdata, exp_w);
    end
    check("stall_cnt", stall_cycles, model_stalls);
    $display("op v=%0d memop=%0d addr=%h delay=%0d out_wdata=%h", v, op, addr, delay, out_wdata);
  endtask

  initial begin
    reset = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset_dut();
    @(negedge clk);
    check_zero_outs("rst");
    @(posedge clk); #1;

    do_op(1, 4'd0, 32'h1234, 32'h0, 32'h0, 1, 5'd5, 0);
    do_op(1, 4'd1, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 5'd3, 0);
    do_op(1, 4'd4, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 5'd4, 0);
    do_op(1, 4'd2, 32'h102, 32'h0, 32'h8001_0000, 1, 5'd6, 0);
    do_op(1, 4'd7, 32'h202, 32'hABCD, 32'h0, 1, 5'd7, 3);
    do_op(1, 4'd3, 32'h101, 32'h0, 32'h0, 1, 5'd8, 2);
    do_op(0, 4'd3, 32'h100, 32'h0, 32'h0, 1, 5'd9, 0);

    for (int i = 0; i < 250; i++) begin
      do_op($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
            32'h1000 + $urandom_range(0, 255), $urandom, $urandom,
            1'($urandom), 5'($urandom), $urandom_range(0, 4));
    end

    // Bus timeout: a valid instruction first so the FAULT clear of out_valid is visible.
    reset_dut();
    do_op(1, 4'd0, 32'h55, 32'h0, 32'h0, 1, 5'd1, 0);
    in_valid = 1; in_memop = 4'd3; in_result = 32'h300; in_wr_reg = 1; in_rd = 5'd2;
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk);
      check("to_req", dmem_req, 1);
      check("to_stall", stall_out, 1);
      check("to_hold_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      dmem_ack = (i == 1);
      @(negedge clk);
      check("flt_bus_fault", bus_fault, 1);
      check("flt_req", dmem_req, 0);
      check("flt_stall", stall_out, 1);
      check("flt_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    dmem_ack = 0;
    check("flt_stallcnt", stall_cycles, TO + 1 + 3);
    reset = 1;
    @(negedge clk);
    check("rst_req_forced", dmem_req, 0);
    check("rst_stall_forced", stall_out, 0);
    @(posedge clk); #1;
    reset = 0;
    drive_idle();
    model_stalls = 0;
    @(negedge clk);
    check_zero_outs("flt_rst");
    @(posedge clk); #1;

    // Reset in WAIT cycle 2, then a stray ack with nothing pending.
    do_op(1, 4'd0, 32'h77, 32'h0, 32'h0, 1, 5'd3, 0);
    in_valid = 1; in_memop = 4'd3; in_result = 32'h400; in_wr_reg = 1; in_rd = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    drive_idle();
    dmem_ack = 1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_req", dmem_req, 0);
    check("stray_stall", stall_out, 0);
    @(posedge clk); #1;
    dmem_ack = 0;
    check("stray_valid", out_valid, 0);
    check("stray_wdata", out_wdata, 0);
    model_stalls = 0;
    do_op(1, 4'd5, 32'h402, 32'h0, 32'hF00D_1234, 1, 5'd10, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
